bit64_alu: RTL and testbench
============================

# bit64_alu

64-bit two's-complement ALU for the Y86-64 execute stage. It performs add, subtract, AND or XOR on two 64-bit operands selected by a 2-bit opcode, and produces a 64-bit result plus a signed-overflow flag. Outputs are registered, so the block adds one pipeline register in front of the condition-code and valE consumers. The encoding of `select_op` matches the Y86 OPq `ifun[1:0]`, so the execute stage drives it directly.

## Interface
- No parameters. Width is fixed at 64 bits.
- One clock; reset is synchronous and active-high.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `select_op`  input  2  operation: 00 = ADD, 01 = SUB, 10 = AND, 11 = XOR.
- `a`  input  64  first operand, signed two's complement. In the execute stage this is valB.
- `b`  input  64  second operand, signed two's complement. In the execute stage this is valA, valC or the constant 8.
- `result`  output  64  registered operation result.
- `overflow`  output  1  registered signed-overflow flag.

## Operation
- ADD (00): `result = a + b`, modulo 2^64; any carry out of bit 63 is discarded.
- SUB (01): `result = a - b`, computed as `a + ~b + 1`.
  - Operand order is fixed: b is subtracted from a. This gives Y86 `subq` (valB − valA) and stack adjust (rsp − 8).
- AND (10): bitwise `a & b`.
- XOR (11): bitwise `a ^ b`.
- Adder structure:
  - ADD and SUB share one 64-bit ripple-carry adder built from 1-bit full-adder cells.
  - For SUB, the b input to the adder is XORed with the SUB select and the carry-in is 1; for ADD the carry-in is 0.
- Overflow rules:
  - ADD: `overflow = (a[63] == b[63]) && (sum[63] != a[63])`.
  - SUB: `overflow = (a[63] != b[63]) && (diff[63] != a[63])`.
  - AND and XOR: `overflow = 0`.
- Carry-out is not an output. No zero or sign flags are produced here; the consumer derives ZF and SF from `result`.
- All combinations of `select_op` are defined; there is no illegal opcode.

## Timing
- Operands and `select_op` are sampled on the rising edge of `clk`.
  - `result` and `overflow` reflect that operation after the same edge. Latency is 1 cycle.
- Throughput: one operation per cycle. Back-to-back operations with different opcodes need no stall and carry no state between operations.
- Reset:
  - When `rst = 1` at a rising edge, `result` is loaded with 64'h0 and `overflow` with 0, whatever the inputs are.
  - Reset has priority over computation.
  - Reset asserted mid-stream discards the operation sampled on that edge.
  - The first operation after reset deasserts appears one cycle after the first edge with `rst = 0`.
- Before the first reset, output values are unspecified.
- The combinational path (`a`/`b`/`select_op` to the register D input) must close within one clock period. The 64-bit ripple carry is the critical path.

## Test plan
- Reset: hold `rst = 1` with `a = b = 64'hFFFF_FFFF_FFFF_FFFF`, op ADD, for 2 cycles -> `result = 0`, `overflow = 0`. Release `rst` -> next edge gives `result = 64'hFFFF_FFFF_FFFF_FFFE`, `overflow = 0`.
- ADD:
  - `a = 64'h7FFF_FFFF_FFFF_FFFF`, `b = 1` -> `result = 64'h8000_0000_0000_0000`, `overflow = 1`.
  - `a = 5`, `b = -3` -> `result = 2`, `overflow = 0`.
- SUB:
  - `a = 64'h100` (rsp), `b = 8` -> `result = 64'hF8`, `overflow = 0`.
  - `a = 64'h8000_0000_0000_0000`, `b = 1` -> `result = 64'h7FFF_FFFF_FFFF_FFFF`, `overflow = 1`.
  - `a = 3`, `b = 7` -> `result = 64'hFFFF_FFFF_FFFF_FFFC`, `overflow = 0`.
- AND and XOR:
  - AND with `a = 64'hFF00_FF00_FF00_FF00`, `b = 64'h0F0F_0F0F_0F0F_0F0F` -> `result = 64'h0F00_0F00_0F00_0F00`, `overflow = 0`.
  - XOR with `a = b = 64'h1234_5678_9ABC_DEF0` -> `result = 0`, `overflow = 0`.
- Pipelining: change the opcode every cycle (ADD, SUB, AND, XOR) with fixed `a = 12`, `b = 10` -> outputs one cycle later are 22, 2, 8, 6 in order, with `overflow` all 0.
- Reset mid-stream: assert `rst` on the edge that samples SUB 9 − 4 -> output is 0 instead of 5. The next op after release (ADD 1 + 1) -> 2.

Source files
------------

// File: rtl/bit64_alu.sv
// 64-bit Y86-64 execute-stage ALU: ADD/SUB/AND/XOR with signed overflow.
// ADD and SUB share a ripple-carry chain of full-adder cells; outputs are registered.
`timescale 1ns/1ps
module bit64_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  select_op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] result,
  output logic        overflow
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  // One full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
    full_add = {(x & y) | (cin & (x ^ y)), x ^ y ^ cin};
  endfunction

  logic        sub_s;
  logic [63:0] b_adj_s;
  logic [63:0] carry_s;
  logic [63:0] sum_s;
  logic [63:0] result_s;
  logic        overflow_s;
  logic [63:0] result_r;
  logic        overflow_r;

  assign sub_s      = (select_op == OP_SUB);
  assign b_adj_s    = b ^ {64{sub_s}};
  assign carry_s[0] = sub_s;

  genvar gi;
  generate
    for (gi = 0; gi < 63; gi = gi + 1) begin : g_ripple
      assign {carry_s[gi+1], sum_s[gi]} = full_add(a[gi], b_adj_s[gi], carry_s[gi]);
    end
  endgenerate

  // Top cell: the carry out of bit 63 has no consumer, so only the sum is formed.
  assign sum_s[63] = a[63] ^ b_adj_s[63] ^ carry_s[63];

  // Operation select and signed-overflow detection.
  always_comb begin
    result_s   = 64'h0;
    overflow_s = 1'b0;
    case (select_op)
      OP_ADD: begin
        result_s   = sum_s;
        overflow_s = (a[63] == b[63]) && (sum_s[63] != a[63]);
      end
      OP_SUB: begin
        result_s   = sum_s;
        overflow_s = (a[63] != b[63]) && (sum_s[63] != a[63]);
      end
      OP_AND: begin
        result_s   = a & b;
        overflow_s = 1'b0;
      end
      OP_XOR: begin
        result_s   = a ^ b;
        overflow_s = 1'b0;
      end
      default: begin
        result_s   = 64'h0;
        overflow_s = 1'b0;
      end
    endcase
  end

  // Output pipeline register; reset wins over the operation sampled on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r   <= 64'h0;
      overflow_r <= 1'b0;
    end else begin
      result_r   <= result_s;
      overflow_r <= overflow_s;
    end
  end

  assign result   = result_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_bit64_alu.sv
// Scoreboard bench for bit64_alu: driver pushes expected values, monitor pops and compares.
`timescale 1ns/1ps
module tb_bit64_alu;

  logic        clk;
  logic        rst;
  logic [1:0]  select_op;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] result;
  logic        overflow;

  typedef struct {
    logic [63:0] res;
    logic        ovf;
    string       name;
  } expect_t;

  expect_t sb_q[$];
  int checks = 0;
  int errors = 0;

  bit64_alu dut (
    .clk(clk),
    .rst(rst),
    .select_op(select_op),
    .a(a),
    .b(b),
    .result(result),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact 65-bit signed arithmetic; overflow means the true value leaves 64-bit range.
  function automatic expect_t model(input logic r, input logic [1:0] op,
                                    input logic [63:0] x, input logic [63:0] y, input string nm);
    expect_t e;
    logic signed [64:0] wide;
    logic signed [64:0] xs;
    logic signed [64:0] ys;
    xs = {x[63], x};
    ys = {y[63], y};
    e.name = nm;
    e.res  = 64'h0;
    e.ovf  = 1'b0;
    if (!r) begin
      case (op)
        2'd0: begin wide = xs + ys; e.res = wide[63:0]; e.ovf = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000); end
        2'd1: begin wide = xs - ys; e.res = wide[63:0]; e.ovf = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000); end
        2'd2: e.res = x & y;
        default: e.res = x ^ y;
      endcase
    end
    return e;
  endfunction

  task automatic drive(input logic r, input logic [1:0] op,
                       input logic [63:0] x, input logic [63:0] y, input string nm);
    @(negedge clk);
    rst       = r;
    select_op = op;
    a         = x;
    b         = y;
    sb_q.push_back(model(r, op, x, y, nm));
  endtask

  function automatic logic [63:0] pick_operand();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'h7FFF_FFFF_FFFF_FFFF;
      1: v = 64'h8000_0000_0000_0000;
      2: v = 64'hFFFF_FFFF_FFFF_FFFF;
      3: v = 64'h0;
      4: v = 64'(unsigned'($urandom_range(0, 16)));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Monitor: one registered result per edge for every issued operation.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (result !== e.res || overflow !== e.ovf) begin
          errors++;
          $display("FAIL %s: got result=%h overflow=%b, expected result=%h overflow=%b",
                   e.name, result, overflow, e.res, e.ovf);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; select_op = 2'b00; a = 64'h0; b = 64'h0;

    drive(1'b1, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "reset_0");
    drive(1'b1, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "reset_1");
    drive(1'b0, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "post_reset_add");
    drive(1'b0, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, "add_ovf");
    drive(1'b0, 2'd0, 64'h5, 64'hFFFF_FFFF_FFFF_FFFD, "add_5_m3");
    drive(1'b0, 2'd1, 64'h100, 64'h8, "sub_rsp");
    drive(1'b0, 2'd1, 64'h8000_0000_0000_0000, 64'h1, "sub_ovf");
    drive(1'b0, 2'd1, 64'h3, 64'h7, "sub_3_7");
    drive(1'b0, 2'd2, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, "and_mask");
    drive(1'b0, 2'd3, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, "xor_self");
    drive(1'b0, 2'd0, 64'd12, 64'd10, "pipe_add");
    drive(1'b0, 2'd1, 64'd12, 64'd10, "pipe_sub");
    drive(1'b0, 2'd2, 64'd12, 64'd10, "pipe_and");
    drive(1'b0, 2'd3, 64'd12, 64'd10, "pipe_xor");
    drive(1'b0, 2'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, "add_neg_ovf");
    drive(1'b0, 2'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "sub_pos_ovf");
    drive(1'b1, 2'd1, 64'd9, 64'd4, "mid_reset_sub");
    drive(1'b0, 2'd0, 64'd1, 64'd1, "after_reset_add");

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)),
            pick_operand(), pick_operand(), "random");
    end

    // Let the last issued operation drain; a leftover entry means the monitor fell behind.
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
